fm_sb_playback: RTL and testbench

FM_SB_PLAYBACK -- requirements
Module: fm_sb_playback

---
 rtl/fm_sb_playback_if.sv | 29 ++
 rtl/fm_sb_playback.sv | 144 ++++++++++++++
 tb/tb_fm_sb_playback.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fm_sb_playback_if.sv
// Write-side beat bus, playback controls and playback/status outputs.
interface fm_sb_playback_if #(
   parameter int unsigned TP_DW  = 51,
   parameter int unsigned AXI_DW = 32,
   parameter int unsigned DEPTH  = 16
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic              axi_wr_en;
   logic [AXI_DW-1:0] axi_wr_data;
   logic [1:0]        pb_mode;
   logic              pb_clear;
   logic [TP_DW-1:0]  pb_data;
   logic              pb_vld;
   logic [CW-1:0]     entry_cnt;
   logic              busy;
   logic              done;
   logic              wr_err;

   modport master (
      output axi_wr_en, axi_wr_data, pb_mode, pb_clear,
      input  pb_data, pb_vld, entry_cnt, busy, done, wr_err
   );

   modport slave (
      input  axi_wr_en, axi_wr_data, pb_mode, pb_clear,
      output pb_data, pb_vld, entry_cnt, busy, done, wr_err
   );
endinterface

// File: rtl/fm_sb_playback.sv
// Stimulus buffer: packs AXI beats into SB_DW words, then plays them back
// single-shot or looped, one entry per cycle.
module fm_sb_playback #(
   parameter int unsigned TP_DW  = 51,
   parameter int unsigned SB_DW  = 64,
   parameter int unsigned AXI_DW = 32,
   parameter int unsigned DEPTH  = 16
) (
   input  logic               clk,
   input  logic               rst,
   fm_sb_playback_if.slave    bus
);
   localparam int unsigned BEATS = SB_DW / AXI_DW;
   localparam int unsigned BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_DONE} state_t;

   state_t             state_q;
   logic [BCW-1:0]     bcnt_q;
   logic [CW-1:0]      cnt_q;
   logic [AW-1:0]      rd_ptr_q;
   logic [SB_DW-1:0]   asm_q;
   logic [SB_DW-1:0]   mem [DEPTH];
   logic [TP_DW-1:0]   pb_data_q;
   logic               pb_vld_q;
   logic               busy_q;
   logic               done_q;
   logic               wr_err_q;

   logic               mode_run_c;
   logic               clear_c;
   logic               accept_c;
   logic               last_beat_c;
   logic               commit_c;
   logic               last_entry_c;
   logic [SB_DW-1:0]   word_c;
   logic [SB_DW-1:0]   rd_word_c;
   logic               unused_rd_c;

   // Qualifiers shared by the write side and the playback FSM
   assign mode_run_c   = (bus.pb_mode == 2'b01) || (bus.pb_mode == 2'b10);
   assign clear_c      = bus.pb_clear && (state_q != ST_PLAY);
   assign accept_c     = bus.axi_wr_en && (state_q == ST_IDLE) &&
                         (cnt_q != CW'(DEPTH)) && !clear_c;
   assign last_beat_c  = (bcnt_q == BCW'(BEATS - 1));
   assign commit_c     = accept_c && last_beat_c;
   assign last_entry_c = (CW'(rd_ptr_q) == (cnt_q - CW'(1)));
   assign rd_word_c    = mem[rd_ptr_q];
   assign unused_rd_c  = ^rd_word_c;

   // Merge the incoming beat into the partially assembled word
   always_comb begin
      word_c = asm_q;
      word_c[int'(bcnt_q) * AXI_DW +: AXI_DW] = bus.axi_wr_data;
   end

   // Beat counter, committed-entry count and sticky drop flag
   always_ff @(posedge clk) begin
      if (rst || clear_c) begin
         bcnt_q   <= '0;
         cnt_q    <= '0;
         wr_err_q <= 1'b0;
      end else if (accept_c) begin
         if (last_beat_c) begin
            bcnt_q <= '0;
            cnt_q  <= cnt_q + CW'(1);
         end else begin
            bcnt_q <= bcnt_q + BCW'(1);
         end
      end else if (bus.axi_wr_en) begin
         wr_err_q <= 1'b1;
      end
   end

   // Assembly register and buffer storage (contents need no reset)
   always_ff @(posedge clk) begin
      if (accept_c) asm_q <= word_c;
      if (commit_c) mem[cnt_q[AW-1:0]] <= word_c;
   end

   // Playback FSM with registered data/valid/status
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         rd_ptr_q  <= '0;
         pb_vld_q  <= 1'b0;
         pb_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               pb_vld_q <= 1'b0;
               if (!clear_c && mode_run_c && (cnt_q != '0)) begin
                  state_q  <= ST_PLAY;
                  rd_ptr_q <= '0;
                  busy_q   <= 1'b1;
               end
            end
            ST_PLAY: begin
               if (!mode_run_c) begin
                  state_q  <= ST_IDLE;
                  pb_vld_q <= 1'b0;
                  busy_q   <= 1'b0;
               end else begin
                  pb_vld_q  <= 1'b1;
                  pb_data_q <= rd_word_c[TP_DW-1:0];
                  if (!last_entry_c) begin
                     rd_ptr_q <= rd_ptr_q + AW'(1);
                  end else if (bus.pb_mode == 2'b10) begin
                     rd_ptr_q <= '0;
                  end else begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               pb_vld_q <= 1'b0;
               if (clear_c || !mode_run_c) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b0;
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               pb_vld_q <= 1'b0;
               busy_q   <= 1'b0;
               done_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pb_data   = pb_data_q;
   assign bus.pb_vld    = pb_vld_q;
   assign bus.entry_cnt = cnt_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.wr_err    = wr_err_q;
endmodule

// File: tb/tb_fm_sb_playback.sv
// Directed bench for fm_sb_playback with default parameters.
module tb_fm_sb_playback;
   localparam int unsigned TP_DW  = 51;
   localparam int unsigned SB_DW  = 64;
   localparam int unsigned AXI_DW = 32;
   localparam int unsigned DEPTH  = 16;

   localparam logic [TP_DW-1:0] E0 = 51'h100_1000_0000;
   localparam logic [TP_DW-1:0] E1 = 51'h101_1000_0001;
   localparam logic [TP_DW-1:0] E2 = 51'h102_1000_0002;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;

   fm_sb_playback_if #(.TP_DW(TP_DW), .AXI_DW(AXI_DW), .DEPTH(DEPTH)) bus ();

   fm_sb_playback #(
      .TP_DW(TP_DW), .SB_DW(SB_DW), .AXI_DW(AXI_DW), .DEPTH(DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [AXI_DW-1:0] d);
      bus.axi_wr_en   = 1'b1;
      bus.axi_wr_data = d;
      tick();
      bus.axi_wr_en   = 1'b0;
   endtask

   task automatic word(input logic [AXI_DW-1:0] lo, input logic [AXI_DW-1:0] hi);
      beat(lo);
      beat(hi);
   endtask

   task automatic clear();
      bus.pb_clear = 1'b1;
      tick();
      bus.pb_clear = 1'b0;
   endtask

   initial begin
      logic [TP_DW-1:0] exp_d;
      bus.axi_wr_en   = 1'b0;
      bus.axi_wr_data = '0;
      bus.pb_mode     = 2'b00;
      bus.pb_clear    = 1'b0;

      // Reset values
      tick(); tick();
      rst = 1'b0;
      chk("rst_vld",  64'(bus.pb_vld), 64'd0);
      chk("rst_data", 64'(bus.pb_data), 64'd0);
      chk("rst_cnt",  64'(bus.entry_cnt), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_err",  64'(bus.wr_err), 64'd0);

      // Two beats pack into one word, single-shot plays it once
      word(32'h1111_1111, 32'h2222_2222);
      chk("pack_cnt", 64'(bus.entry_cnt), 64'd1);
      bus.pb_mode = 2'b01;
      tick();
      chk("ss1_busy", 64'(bus.busy), 64'd1);
      chk("ss1_vld0", 64'(bus.pb_vld), 64'd0);
      tick();
      chk("ss1_vld",  64'(bus.pb_vld), 64'd1);
      chk("ss1_data", 64'(bus.pb_data), 64'(51'h2_2222_1111_1111));
      chk("ss1_done", 64'(bus.done), 64'd1);
      tick();
      chk("ss1_vld_end", 64'(bus.pb_vld), 64'd0);
      chk("ss1_hold",    64'(bus.pb_data), 64'(51'h2_2222_1111_1111));
      bus.pb_mode = 2'b00;
      tick();
      chk("ss1_idle", 64'(bus.done), 64'd0);
      clear();
      chk("clr_cnt", 64'(bus.entry_cnt), 64'd0);

      // Three entries single-shot, back to back then DONE
      word(32'h1000_0000, 32'h100);
      word(32'h1000_0001, 32'h101);
      word(32'h1000_0002, 32'h102);
      chk("ss3_cnt", 64'(bus.entry_cnt), 64'd3);
      bus.pb_mode = 2'b01;
      tick();
      tick();
      chk("ss3_v0", 64'(bus.pb_vld), 64'd1);
      chk("ss3_d0", 64'(bus.pb_data), 64'(E0));
      tick();
      chk("ss3_v1", 64'(bus.pb_vld), 64'd1);
      chk("ss3_d1", 64'(bus.pb_data), 64'(E1));
      tick();
      chk("ss3_v2", 64'(bus.pb_vld), 64'd1);
      chk("ss3_d2", 64'(bus.pb_data), 64'(E2));
      chk("ss3_done", 64'(bus.done), 64'd1);
      tick();
      chk("ss3_v3", 64'(bus.pb_vld), 64'd0);
      tick();
      chk("ss3_stay_done", 64'(bus.done), 64'd1);
      chk("ss3_no_replay", 64'(bus.pb_vld), 64'd0);
      bus.pb_mode = 2'b00;
      tick();
      chk("ss3_idle_done", 64'(bus.done), 64'd0);
      chk("ss3_idle_busy", 64'(bus.busy), 64'd0);
      clear();

      // Loop over two entries, then switch to single-shot mid-pass
      word(32'h1000_0000, 32'h100);
      word(32'h1000_0001, 32'h101);
      bus.pb_mode = 2'b10;
      tick();
      chk("lp_busy", 64'(bus.busy), 64'd1);
      chk("lp_vld0", 64'(bus.pb_vld), 64'd0);
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk("lp_vld",  64'(bus.pb_vld), 64'd1);
         chk("lp_data", 64'(bus.pb_data), (i % 2 == 1) ? 64'(E0) : 64'(E1));
      end
      bus.pb_mode = 2'b01;
      tick();
      chk("lp2ss_data", 64'(bus.pb_data), 64'(E1));
      chk("lp2ss_done", 64'(bus.done), 64'd1);
      tick();
      chk("lp2ss_vld", 64'(bus.pb_vld), 64'd0);
      bus.pb_mode = 2'b00;
      tick();

      // Abort loop with mode 00
      bus.pb_mode = 2'b10;
      tick(); tick(); tick();
      chk("ab_data_pre", 64'(bus.pb_data), 64'(E1));
      bus.pb_mode = 2'b00;
      tick();
      chk("ab_vld",  64'(bus.pb_vld), 64'd0);
      chk("ab_busy", 64'(bus.busy), 64'd0);
      chk("ab_hold", 64'(bus.pb_data), 64'(E1));
      chk("ab_cnt",  64'(bus.entry_cnt), 64'd2);

      // Reset pulsed mid-loop
      bus.pb_mode = 2'b10;
      tick(); tick(); tick();
      rst = 1'b1;
      bus.pb_mode = 2'b00;
      tick();
      rst = 1'b0;
      chk("mrst_vld",  64'(bus.pb_vld), 64'd0);
      chk("mrst_data", 64'(bus.pb_data), 64'd0);
      chk("mrst_cnt",  64'(bus.entry_cnt), 64'd0);
      chk("mrst_busy", 64'(bus.busy), 64'd0);
      bus.pb_mode = 2'b01;
      tick(); tick();
      chk("empty_busy", 64'(bus.busy), 64'd0);
      chk("empty_vld",  64'(bus.pb_vld), 64'd0);
      bus.pb_mode = 2'b00;
      tick();

      // Beat during PLAY is dropped; clear discards a partial word
      word(32'h1000_0000, 32'h100);
      bus.pb_mode = 2'b10;
      tick();
      beat(32'h5555_5555);
      chk("play_err", 64'(bus.wr_err), 64'd1);
      chk("play_cnt", 64'(bus.entry_cnt), 64'd1);
      bus.pb_mode = 2'b00;
      tick();
      clear();
      chk("clr_err", 64'(bus.wr_err), 64'd0);
      chk("clr_cnt2", 64'(bus.entry_cnt), 64'd0);
      beat(32'hDEAD_BEEF);
      clear();
      beat(32'h3333_3333);
      chk("fresh_cnt0", 64'(bus.entry_cnt), 64'd0);
      beat(32'h0004_4444);
      chk("fresh_cnt1", 64'(bus.entry_cnt), 64'd1);
      bus.pb_mode = 2'b01;
      tick(); tick();
      chk("fresh_data", 64'(bus.pb_data), 64'(51'h4_4444_3333_3333));
      bus.pb_mode = 2'b00;
      tick(); tick();
      clear();

      // Clear coinciding with a final beat: clear wins
      beat(32'h1);
      bus.axi_wr_en   = 1'b1;
      bus.axi_wr_data = 32'h2;
      bus.pb_clear    = 1'b1;
      tick();
      bus.axi_wr_en   = 1'b0;
      bus.pb_clear    = 1'b0;
      chk("clrbeat_cnt", 64'(bus.entry_cnt), 64'd0);
      chk("clrbeat_err", 64'(bus.wr_err), 64'd0);
      beat(32'hA);
      chk("clrbeat_bc", 64'(bus.entry_cnt), 64'd0);
      beat(32'hB);
      chk("clrbeat_word", 64'(bus.entry_cnt), 64'd1);
      clear();

      // Overfill: DEPTH*2+1 beats, then play all entries
      for (int i = 0; i < int'(DEPTH) * 2 + 1; i++) beat(32'(i));
      chk("full_cnt", 64'(bus.entry_cnt), 64'(DEPTH));
      chk("full_err", 64'(bus.wr_err), 64'd1);
      bus.pb_mode = 2'b01;
      tick();
      for (int k = 0; k < int'(DEPTH); k++) begin
         tick();
         exp_d = {19'(2 * k + 1), 32'(2 * k)};
         chk("full_vld",  64'(bus.pb_vld), 64'd1);
         chk("full_data", 64'(bus.pb_data), 64'(exp_d));
      end
      chk("full_done", 64'(bus.done), 64'd1);
      tick();
      chk("full_vld_end", 64'(bus.pb_vld), 64'd0);
      clear();
      chk("dclr_cnt",  64'(bus.entry_cnt), 64'd0);
      chk("dclr_err",  64'(bus.wr_err), 64'd0);
      chk("dclr_done", 64'(bus.done), 64'd0);
      bus.pb_mode = 2'b00;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
